// File: rtl/cpu5_mc_ctrl_pkg.sv
// Shared encodings for the cpu5 multicycle controller: states, opcodes, ALU codes,
// immediate formats and datapath mux selects.
`ifndef CPU5_MC_CTRL_DEFS
`define CPU5_MC_CTRL_DEFS
`define CPU5_ALU_CONTROL_SIZE 4
`define CPU5_IMMTYPE_SIZE 2
`define CPU5_IMMTYPE_I 2'd0
`define CPU5_IMMTYPE_S 2'd1
`define CPU5_IMMTYPE_B 2'd2
`define CPU5_IMMTYPE_J 2'd3
`endif

package cpu5_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALPC  = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_ADD  = 4'd0;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_SUB  = 4'd1;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_AND  = 4'd2;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_OR   = 4'd3;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_XOR  = 4'd4;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_SLT  = 4'd5;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_SLTU = 4'd6;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_SLL  = 4'd7;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_SRL  = 4'd8;
  localparam logic [`CPU5_ALU_CONTROL_SIZE-1:0] ALU_SRA  = 4'd9;

  localparam logic [`CPU5_IMMTYPE_SIZE-1:0] IMM_I = `CPU5_IMMTYPE_I;
  localparam logic [`CPU5_IMMTYPE_SIZE-1:0] IMM_S = `CPU5_IMMTYPE_S;
  localparam logic [`CPU5_IMMTYPE_SIZE-1:0] IMM_B = `CPU5_IMMTYPE_B;
  localparam logic [`CPU5_IMMTYPE_SIZE-1:0] IMM_J = `CPU5_IMMTYPE_J;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // States whose exit back to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_JALPC);
  endfunction

endpackage

// File: rtl/cpu5_aludec.sv
// ALU control decode for the cpu5 multicycle controller: maps the current state
// and funct3/funct7[5] to the ALU operation.
module cpu5_aludec
  import cpu5_mc_ctrl_pkg::*;
(
  input  logic [3:0]                        state,
  input  logic [2:0]                        funct3,
  input  logic                              funct7b5,
  output logic [`CPU5_ALU_CONTROL_SIZE-1:0] alucontrol
);

  logic is_execr;
  logic is_exec;

  assign is_execr = (state == S_EXECR);
  assign is_exec  = is_execr || (state == S_EXECI);

  always_comb begin
    alucontrol = ALU_ADD;
    if (state == S_BRANCH) begin
      alucontrol = ALU_SUB;
    end else if (is_exec) begin
      case (funct3)
        // funct7[5] selects SUB only for register ops; addi reuses that bit as imm[10].
        3'b000:  alucontrol = (is_execr && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alucontrol = ALU_SLL;
        3'b010:  alucontrol = ALU_SLT;
        3'b011:  alucontrol = ALU_SLTU;
        3'b100:  alucontrol = ALU_XOR;
        3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alucontrol = ALU_OR;
        3'b111:  alucontrol = ALU_AND;
        default: alucontrol = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/cpu5_mc_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the cpu5 RV32 datapath with a
// shared req/ack memory port and ack watchdog. Optional counters: CPU5_MC_PERFCNT_EN.
module cpu5_mc_ctrl
  import cpu5_mc_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       instr,
  input  logic                              zero,
  input  logic                              mem_ack,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic                              adrsrc,
  output logic                              irwrite,
  output logic                              pcen,
  output logic                              regwrite,
  output logic [1:0]                        resultsrc,
  output logic [1:0]                        alusrca,
  output logic [1:0]                        alusrcb,
  output logic [`CPU5_ALU_CONTROL_SIZE-1:0] alucontrol,
  output logic [`CPU5_IMMTYPE_SIZE-1:0]     immtype,
  output logic                              illegal,
  output logic                              bus_err
`ifdef CPU5_MC_PERFCNT_EN
  ,
  output logic [31:0]                       cycle_cnt,
  output logic [31:0]                       instret_cnt
`endif
);

  localparam int WD_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = '1;

  state_t          state;
  state_t          state_nx;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            set_illegal;
  logic            set_bus_err;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign unused_instr = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  // Expires on the request cycle whose un-acked increment would reach ACK_TIMEOUT.
  assign wd_hit = (ACK_TIMEOUT != 0) && (int'(wd_cnt) == ACK_TIMEOUT - 1);

  cpu5_aludec u_aludec (
    .state      (state),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      wd_cnt  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        wd_cnt <= '0;
      end else if (mem_req && !mem_ack && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adrsrc      = 1'b0;
    irwrite     = 1'b0;
    pcen        = 1'b0;
    regwrite    = 1'b0;
    resultsrc   = RES_ALUOUT;
    alusrca     = SRCA_PC;
    alusrcb     = SRCB_RS2;
    immtype     = IMM_I;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;

    case (state)
      S_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        // IR and pc only move on the ack cycle, so wait states never skip an instruction.
        if (mem_ack) begin
          irwrite  = 1'b1;
          pcen     = 1'b1;
          state_nx = S_DECODE;
        end
      end

      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        immtype = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_RTYPE:          state_nx = S_EXECR;
          OP_ITYPE:          state_nx = S_EXECI;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          default: begin
            state_nx    = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca  = SRCA_RS1;
        alusrcb  = SRCB_IMM;
        immtype  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        state_nx = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
        if (mem_ack) state_nx = S_MEMWB;
      end

      S_MEMWB: begin
        resultsrc = RES_RDATA;
        regwrite  = 1'b1;
        state_nx  = S_FETCH;
      end

      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adrsrc  = 1'b1;
        if (mem_ack) state_nx = S_FETCH;
      end

      S_EXECR: begin
        alusrca  = SRCA_RS1;
        alusrcb  = SRCB_RS2;
        state_nx = S_ALUWB;
      end

      S_EXECI: begin
        alusrca  = SRCA_RS1;
        alusrcb  = SRCB_IMM;
        immtype  = IMM_I;
        state_nx = S_ALUWB;
      end

      S_ALUWB: begin
        resultsrc = RES_ALUOUT;
        regwrite  = 1'b1;
        state_nx  = S_FETCH;
      end

      S_BRANCH: begin
        alusrca   = SRCA_RS1;
        alusrcb   = SRCB_RS2;
        resultsrc = RES_ALUOUT;
        state_nx  = S_FETCH;
        case (funct3)
          3'b000:  pcen = zero;
          3'b001:  pcen = ~zero;
          default: begin
            state_nx    = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end

      S_JAL: begin
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALU;
        regwrite  = 1'b1;
        state_nx  = S_JALPC;
      end

      // aluout was overwritten with oldpc+4 in JAL, so the jump target is rebuilt live.
      S_JALPC: begin
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_IMM;
        immtype   = IMM_J;
        resultsrc = RES_ALU;
        pcen      = 1'b1;
        state_nx  = S_FETCH;
      end

      S_HALT: state_nx = S_HALT;

      default: state_nx = S_IDLE;
    endcase

    if (mem_req && !mem_ack && wd_hit) begin
      state_nx    = S_HALT;
      set_bus_err = 1'b1;
    end
  end

`ifdef CPU5_MC_PERFCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if ((state != S_IDLE) && (state != S_HALT)) cycle_cnt <= cycle_cnt + 32'd1;
      if ((state_nx == S_FETCH) && is_retire_state(state)) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu5_mc_ctrl.sv
// Directed bench for cpu5_mc_ctrl: instruction walks with a reactive memory ack,
// illegal-opcode halt, mid-access reset and watchdog timeout (ACK_TIMEOUT=4).
module tb_cpu5_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, adrsrc, irwrite, pcen, regwrite;
  logic [1:0]  resultsrc, alusrca, alusrcb;
  logic [`CPU5_ALU_CONTROL_SIZE-1:0] alucontrol;
  logic [`CPU5_IMMTYPE_SIZE-1:0]     immtype;
  logic        illegal, bus_err;
`ifdef CPU5_MC_PERFCNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  cpu5_mc_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adrsrc     (adrsrc),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .immtype    (immtype),
    .illegal    (illegal),
    .bus_err    (bus_err)
`ifdef CPU5_MC_PERFCNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // All controller outputs packed; illegal is bit 1, bus_err bit 0.
  logic [31:0] ctl;
  assign ctl = {12'd0, mem_req, mem_we, adrsrc, irwrite, pcen, regwrite,
                resultsrc, alusrca, alusrcb, alucontrol, immtype, illegal, bus_err};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-instruction observations, cycle index 0 = first FETCH cycle.
  int          r_rw, r_pc, r_ir, r_we, r_drop;
  logic [31:0] r_alu2, r_imm1, r_imm2;

  // Memory model acks fetch after fwait wait cycles and data access after mwait;
  // ack is held high whenever no request is pending, which the DUT must ignore.
  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait, input int ncyc);
    int   mcyc;
    logic pend, p_adr, p_we;
    mcyc = 0; pend = 1'b0; p_adr = 1'b0; p_we = 1'b0;
    r_rw = -1; r_pc = 0; r_ir = 0; r_we = 0; r_drop = 0;
    r_alu2 = '0; r_imm1 = '0; r_imm2 = '0;
    for (int c = 0; c < ncyc; c++) begin
      instr = ins;
      if (mem_req && !adrsrc) mem_ack = (c == fwait);
      else if (mem_req && adrsrc) begin
        mem_ack = (mcyc == mwait);
        mcyc++;
      end else mem_ack = 1'b1;
      #1;
      if (pend && (!mem_req || adrsrc != p_adr || mem_we != p_we)) r_drop++;
      pend  = mem_req && !mem_ack;
      p_adr = adrsrc;
      p_we  = mem_we;
      if (regwrite && r_rw < 0) r_rw = c;
      if (pcen) r_pc++;
      if (irwrite) r_ir++;
      if (mem_we) r_we++;
      if (c == 1) r_imm1 = 32'(immtype);
      if (c == 2) begin
        r_alu2 = 32'(alucontrol);
        r_imm2 = 32'(immtype);
      end
      cyc();
    end
    mem_ack = 1'b0;
  endtask

  task automatic expect_refetch(input string tag);
    check(tag, {30'd0, mem_req, adrsrc}, 32'h2);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check(tag, ctl, 32'h0);
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded its time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    int bad;

    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_outs", ctl, 32'h0);
    end
    reset = 1'b1;
    #1;
    check("idle_outs", ctl, 32'h0);
    cyc();
    check("first_fetch", {30'd0, mem_req, adrsrc}, 32'h2);

    // add x3,x1,x2 with zero-wait fetch
    run_instr(32'h002081B3, 0, 0, 4);
    check("add_rw_cycle", r_rw, 3);
    check("add_pcen", r_pc, 1);
    check("add_irwrite", r_ir, 1);
    check("add_alu", r_alu2, 32'd0);
    expect_refetch("add_refetch");

    // sub x3,x1,x2
    run_instr(32'h402081B3, 0, 0, 4);
    check("sub_alu", r_alu2, 32'd1);
    check("sub_rw_cycle", r_rw, 3);

    // addi x1,x1,-1024: imm[10] sits in the funct7[5] position but must stay ADD
    run_instr(32'hC0008093, 0, 0, 4);
    check("addi_alu", r_alu2, 32'd0);
    check("addi_imm", r_imm2, 32'd0);

    // srai x1,x1,3
    run_instr(32'h4030D093, 0, 0, 4);
    check("srai_alu", r_alu2, 32'd9);
    check("srai_rw_cycle", r_rw, 3);

    // lw x5,8(x1): fetch ack on the 4th request cycle (the watchdog limit), read ack on 3rd
    run_instr(32'h0080A283, 3, 2, 10);
    check("lw_rw_cycle", r_rw, 9);
    check("lw_req_hold", r_drop, 0);
    check("lw_pcen", r_pc, 1);
    check("lw_no_buserr", 32'(bus_err), 0);
    expect_refetch("lw_refetch");

    // sw x2,4(x1)
    run_instr(32'h0020A223, 0, 0, 4);
    check("sw_we", r_we, 1);
    check("sw_imm", r_imm2, 32'd1);
    check("sw_no_rw", r_rw, -1);
    expect_refetch("sw_refetch");

    // beq taken / not taken, bne not-equal
    zero = 1'b1;
    run_instr(32'h00208463, 0, 0, 3);
    check("beq_taken_pcen", r_pc, 2);
    check("beq_imm", r_imm1, 32'd2);
    expect_refetch("beq_taken_refetch");
    zero = 1'b0;
    run_instr(32'h00208463, 0, 0, 3);
    check("beq_fall_pcen", r_pc, 1);
    expect_refetch("beq_fall_refetch");
    run_instr(32'h00209463, 0, 0, 3);
    check("bne_taken_pcen", r_pc, 2);

    // jal x1,16
    run_instr(32'h010000EF, 0, 0, 4);
    check("jal_imm", r_imm1, 32'd3);
    check("jal_rw_cycle", r_rw, 2);
    check("jal_pcen", r_pc, 2);
    expect_refetch("jal_refetch");

    // blt is unsupported: halts with illegal, no branch
    run_instr(32'h0020C463, 0, 0, 3);
    check("blt_pcen", r_pc, 1);
    check("blt_halt", ctl, 32'h2);
    do_reset("rst_after_blt");

    // opcode 0x7F: illegal and absorbing HALT
    run_instr(32'h0000007F, 0, 0, 2);
    check("ill_halt", ctl, 32'h2);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = i[0];
      #1;
      if (mem_req || pcen || regwrite || irwrite) bad++;
      cyc();
    end
    mem_ack = 1'b0;
    check("ill_hold", bad, 0);
    check("ill_sticky", 32'(illegal), 1);
    do_reset("rst_after_ill");

    // reset asserted while a fetch is waiting drops the request at once
    check("mid_req_up", 32'(mem_req), 1);
    cyc();
    #3;
    reset = 1'b0;
    #1;
    check("mid_req_drop", 32'(mem_req), 0);
    cyc();
    reset = 1'b1;
    cyc();

    // watchdog: no ack ever
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (!mem_req) break;
      n++;
      cyc();
    end
    check("wd_req_cycles", n, 4);
    check("wd_halt", ctl, 32'h1);
    reset = 1'b0;
    #1;
    check("wd_rst_clear", 32'(bus_err), 0);
    cyc();
    reset = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
